// File: rtl/shift_unit.sv
// shift_unit: RV32I shift execution unit (SLL/SRL/SRA and their immediate forms).
// Iterative by default, shifting STEP bits per cycle. Defining the macro
// SHIFT_UNIT_FAST_EN compiles in a single-cycle barrel shifter instead.
//
// Handshake: start_i is sampled on a rising edge only while the unit is in IDLE
// or DONE. A sampled start is consumed immediately and never queued. A start
// seen while busy_o=1 is dropped. done_o is a one-cycle strobe, and result_o/rd_o
// are valid in that cycle. They hold their value until the next done or reset.
// There is no back-pressure on the result side.
module shift_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic [4:0]      shamt_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL   = 2'b00;
  localparam logic [1:0] OP_SRL   = 2'b01;
  localparam logic [1:0] OP_SRA   = 2'b11;
  localparam logic [5:0] STEP_AMT = 6'(STEP);

  state_t          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] work_q;
  logic [4:0]      rem_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;
  logic            busy_q;
  logic            done_q;

  logic [5:0]      amt;
  logic [XLEN-1:0] work_d;
  logic [4:0]      rem_d;

  // One iteration: shift the working register by min(STEP, remaining).
  // SRA keeps the sign because the MSB of the working value never changes.
  always_comb begin
    amt    = (STEP_AMT < {1'b0, rem_q}) ? STEP_AMT : {1'b0, rem_q};
    rem_d  = rem_q - amt[4:0];
    work_d = work_q;
    case (op_q)
      OP_SLL:  work_d = work_q << amt;
      OP_SRL:  work_d = work_q >> amt;
      OP_SRA:  work_d = $signed(work_q) >>> amt;
      default: work_d = work_q;
    endcase
  end

`ifdef SHIFT_UNIT_FAST_EN
  logic [XLEN-1:0] fast_res_d;

  // Single-cycle barrel shift computed straight from the issue inputs.
  always_comb begin
    fast_res_d = operand_i;
    case (op_i)
      OP_SLL:  fast_res_d = operand_i << shamt_i;
      OP_SRL:  fast_res_d = operand_i >> shamt_i;
      OP_SRA:  fast_res_d = $signed(operand_i) >>> shamt_i;
      default: fast_res_d = operand_i;
    endcase
  end
`endif

  // Control FSM with registered busy/done strobes and result capture on DONE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      work_q   <= '0;
      rem_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            op_q   <= op_i;
            work_q <= operand_i;
            rem_q  <= shamt_i;
            rd_q   <= rd_i;
`ifdef SHIFT_UNIT_FAST_EN
            state_q  <= DONE;
            result_q <= fast_res_d;
            rd_out_q <= rd_i;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
`else
            if (shamt_i != 5'd0) begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q  <= DONE;
              result_q <= operand_i;
              rd_out_q <= rd_i;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
`endif
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == 5'd0) begin
            state_q  <= DONE;
            result_q <= work_d;
            rd_out_q <= rd_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_out_q;
  assign state_o  = state_q;

endmodule

// File: doc/shift_unit.md
# shift_unit

Multi-cycle shifter executing the RV32I shift instructions (SLL/SLLI, SRL/SRLI, SRA/SRAI) for the CPU execute stage. Decode issues one shift with its operand, shift amount and destination register. The unit returns the result and destination index on a one-cycle done strobe, and the CPU writes it into the register file. Shifts are iterative, STEP bits per cycle, to keep the critical path short on the FPGA. A single-cycle barrel mode can be compiled in.

## Interface
- XLEN, 32: datapath width.
- STEP, 1: bits shifted per iterative cycle; power of two, 1..16.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  issue request, sampled on rising edge.
- op_i  in  2  00 SLL, 01 SRL, 11 SRA, 10 reserved (passes operand unchanged).
- operand_i  in  XLEN  value to shift (rs1).
- shamt_i  in  5  shift amount (rs2[4:0] or imm[4:0]).
- rd_i  in  5  destination register index.
- busy_o  out  1  shift in progress; start_i ignored.
- done_o  out  1  one-cycle strobe; result_o/rd_o valid.
- result_o  out  XLEN  shifted result, held until next done.
- rd_o  out  5  destination index, held until next done.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE/DONE with start_i=1:
  - Latch operand, op, rd and remaining=shamt_i.
  - Go to SHIFT if shamt_i≠0, else DONE.
- IDLE/DONE with start_i=0: go to IDLE.
- SHIFT: each edge shifts the working register by n=min(STEP, remaining) and sets remaining-=n.
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA fills with the original bit XLEN-1 at the MSB.
- SHIFT with remaining reaching 0: go to DONE on that edge.
- Entry into DONE: register result_o and rd_o.
- done_o=1 exactly while in DONE.
- busy_o=1 exactly while in SHIFT.
- start_i in SHIFT is ignored and dropped; it is not queued.
- Reserved op=10: result equals operand; latency is the same as for SLL.
- Only shamt_i[4:0] is used; no range error is possible.

## Timing
- Reset values: state IDLE; busy_o=0; done_o=0; result_o=0; rd_o=0; working register and remaining are 0.
- Start sampled at edge E0, with k=ceil(shamt/STEP). done_o is high for the single cycle after edge E0+k.
  - k=0: done_o is high in the cycle after E0.
- busy_o is high after edges E0..E0+k-1.
- Back-to-back: a start sampled in the DONE cycle is accepted at that edge, so throughput is one shift per k+1 cycles.
- Reset asserted mid-operation:
  - Immediate (asynchronous) return to IDLE with all outputs cleared.
  - No done_o for the aborted shift.
  - First start is accepted on the first rising edge after reset_n deasserts.
- result_o and rd_o change only on entry to DONE or on reset.

## Configuration
- SHIFT_UNIT_FAST_EN defined:
  - Combinational barrel shift in one cycle; STEP is ignored.
  - Start at E0 goes straight to DONE, with done_o high in the cycle after E0 for any shamt.
  - busy_o is tied to 0 and the SHIFT state is never entered.
- SHIFT_UNIT_FAST_EN undefined: iterative behaviour as specified above.

## Test plan
- SRL, STEP=1, operand 0x00000090, shamt 4, rd 7 at E0: busy_o high after E0..E3, then done_o high after E4 with result_o=0x00000009 and rd_o=7.
- SRA 0x80000000 by 31 gives 0xFFFFFFFF after k=31. SRL of the same operand by 31 gives 0x00000001. Also check STEP=4: SLL 0x00000001 by 31 gives 0x80000000 with done after E0+8.
- SLL 0x12345678 by 0: done_o high in the cycle after E0, result 0x12345678, busy_o never high.
- Shift in progress plus a second start with different rd while busy_o=1: the second start is ignored, only one done_o fires, and it carries the first rd. A start in the DONE cycle yields a second done k+1 cycles later.
- Reset pulsed low at E2 of an 8-bit shift: outputs are 0 immediately, no done_o follows, and a new shift after release completes normally.
- SHIFT_UNIT_FAST_EN defined: SRL 0x00000090 by 4 and SRA 0x80000000 by 31 each give done_o in the cycle after E0, with results 0x9 and 0xFFFFFFFF and busy_o always 0.
